aud_recorder: RTL
=================

# aud_recorder

Captures 16-bit left-channel PCM words from the WM8731 ADC serial stream and writes them sequentially into the external SRAM. It sits between the codec ADC pins (AUD_ADCDAT/AUD_ADCLRCK, clocked by AUD_BCLK) and the SRAM write port arbitrated inside Top. It is controlled by the debounced record/pause/stop key pulses. It reports recorded length to the player and display paths.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- ADDR_MAX, 20'hFFFFF, last writable address; recording auto-stops after writing it

Ports:
- i_clk  in  1  codec bit clock (AUD_BCLK); all logic on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_lrc  in  1  ADC LR clock (AUD_ADCLRCK); low = left channel
- i_data  in  1  ADC serial data (AUD_ADCDAT), MSB first
- i_start  in  1  one-cycle pulse: start new recording (from IDLE) or resume (from PAUSE)
- i_pause  in  1  one-cycle pulse: pause
- i_stop  in  1  one-cycle pulse: stop
- o_address  out  ADDR_W  SRAM write address
- o_data  out  16  sample word to SRAM
- o_wen  out  1  one-cycle SRAM write strobe
- o_len  out  ADDR_W  words written in current/last recording
- o_state  out  2  0 IDLE, 1 RECORDING, 2 PAUSED
- o_full  out  1  set when memory filled; cleared by next i_start
- o_peak  out  16  peak |sample| since start (see Configuration)

## Operation
- States: IDLE, WAIT_L, SKIP, SHIFT, WRITE, WAIT_H, PAUSE. o_state reports IDLE → 0, PAUSE → 2, all others → 1.
- IDLE + i_start → WAIT_L. Also clears o_address, o_len, o_full, o_peak.
- WAIT_L: waits for i_lrc sampled low when previously high (falling edge), then → SKIP.
- SKIP: one i_clk (I2S one-bit delay), then → SHIFT.
- SHIFT: shifts i_data into a 16-bit register MSB first for exactly 16 cycles, then → WRITE.
- WRITE: o_data ← shift reg, o_wen=1 for one cycle. Next cycle: o_len += 1. If o_address == ADDR_MAX → IDLE with o_full=1; else o_address += 1 and → WAIT_H.
- WAIT_H: waits for i_lrc high, then → WAIT_L. Right channel is ignored.
- Priority on simultaneous pulses: i_stop > i_pause > i_start.
- i_stop in any non-IDLE state → IDLE next cycle. A partially shifted word is discarded. o_len and o_address are held.
- i_pause in a recording state → PAUSE; the partial word is discarded. In PAUSE, i_start → WAIT_L resuming at the current o_address. i_pause in PAUSE is ignored.
- i_start in a recording state and i_pause in IDLE are ignored.
- o_data is held between writes. o_wen is never high outside WRITE.

## Timing
- Reset: state IDLE; o_address=0, o_data=0, o_wen=0, o_len=0, o_state=0, o_full=0, o_peak=0, shift reg=0.
- i_lrc falling edge at cycle t: first (MSB) bit sampled at t+2, LSB at t+17, o_wen high at t+18, o_address/o_len update visible at t+19.
- Control pulses are sampled every cycle. State change is visible on o_state the following cycle.
- One word per LR frame; ≥32 BCLK per frame guaranteed by codec configuration.

## Configuration
- AUD_REC_PEAK_EN defined: o_peak tracks max of |o_data| over words written since the last i_start from IDLE. Two's-complement abs; 16'h8000 saturates to 16'h7FFF. Updated on the o_wen cycle and visible the next cycle.
- Undefined: o_peak tied to 0, no peak logic synthesized.

## Test plan
- Reset then i_start; drive one frame with left word 16'hA5C3 → o_wen one cycle at t+18, o_data=16'hA5C3, o_address=0, then o_address=1, o_len=1.
- Three frames of 16'h0001, 16'h0002, 16'h0003 followed by i_stop → three writes at addresses 0,1,2; o_len=3, o_state=0; no further o_wen.
- i_pause at SHIFT bit 8 of the second word, then i_start, then frame 16'h1234 → the partial word is not written; 16'h1234 goes to address 1; o_len=2.
- ADDR_MAX=3, five frames → exactly four writes (addresses 0–3), then o_state=0, o_full=1. A later i_start clears o_full and o_address.
- i_stop and i_pause asserted in the same cycle during recording → o_state=0. Reset asserted mid-SHIFT → all outputs return to reset values next cycle.
- With AUD_REC_PEAK_EN, words 16'h0100, 16'hF000, 16'h8000 → o_peak = 16'h0100, then 16'h1000, then 16'h7FFF. Without the macro, o_peak stays 0.

Source files
------------

// File: rtl/aud_recorder_if.sv
// Recorder signal bundle: codec ADC pins and key pulses in, SRAM write port and status out.
// Latency: none (wires only).
// Backpressure: none; the SRAM port is a fire-and-forget write strobe.
// Modports: slave = the recorder itself, master = the surrounding Top / bench side.
interface aud_recorder_if #(
    parameter int ADDR_W = 20
);
    logic              i_lrc;      // ADC LR clock, low = left channel
    logic              i_data;     // ADC serial data, MSB first
    logic              i_start;    // start / resume pulse
    logic              i_pause;    // pause pulse
    logic              i_stop;     // stop pulse
    logic [ADDR_W-1:0] o_address;  // SRAM write address
    logic [15:0]       o_data;     // sample word to SRAM
    logic              o_wen;      // one-cycle SRAM write strobe
    logic [ADDR_W-1:0] o_len;      // words written in current/last recording
    logic [1:0]        o_state;    // 0 idle, 1 recording, 2 paused
    logic              o_full;     // memory filled
    logic [15:0]       o_peak;     // peak |sample| since start

    modport slave (
        input  i_lrc, i_data, i_start, i_pause, i_stop,
        output o_address, o_data, o_wen, o_len, o_state, o_full, o_peak
    );

    modport master (
        output i_lrc, i_data, i_start, i_pause, i_stop,
        input  o_address, o_data, o_wen, o_len, o_state, o_full, o_peak
    );
endinterface

// File: rtl/aud_recorder.sv
// Captures left-channel 16-bit I2S ADC words and writes them sequentially into SRAM.
// Latency: LRC falling edge at t -> MSB at t+2, LSB at t+17, o_wen at t+18, addr/len update at t+19.
// Backpressure: none; the SRAM port must accept every strobe (one word per LR frame).
// Ports: i_clk (AUD_BCLK), i_rst_n (sync, active-low), bus (aud_recorder_if.slave).
// Optional macro AUD_REC_PEAK_EN enables the o_peak tracker; otherwise o_peak is tied to 0.
module aud_recorder #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(20'hFFFFF)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    aud_recorder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_L, S_SKIP, S_SHIFT, S_WRITE, S_WAIT_H, S_PAUSE
    } state_t;

    state_t            state_q, state_d;
    logic              lrc_q;
    logic [15:0]       shift_q;
    logic [15:0]       shift_nxt;
    logic [3:0]        bit_cnt_q;
    logic [15:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic              full_q;
    logic              start_new;   // fresh recording from IDLE: clear counters
    logic              wen;
    logic [1:0]        state_out;

    assign shift_nxt = {shift_q[14:0], bus.i_data};

    always_comb begin
        state_d   = state_q;
        start_new = 1'b0;
        wen       = 1'b0;
        state_out = 2'd1;
        case (state_q)
            S_IDLE: begin
                state_out = 2'd0;
                // stop/pause outrank start even though they do nothing here
                if (bus.i_start && !bus.i_pause && !bus.i_stop) begin
                    state_d   = S_WAIT_L;
                    start_new = 1'b1;
                end
            end
            S_PAUSE: begin
                state_out = 2'd2;
                if (bus.i_stop)
                    state_d = S_IDLE;
                else if (bus.i_start && !bus.i_pause)
                    state_d = S_WAIT_L;
            end
            S_WRITE: begin
                // the word is committed this cycle regardless of control pulses
                wen = 1'b1;
                if (addr_q == ADDR_MAX || bus.i_stop)
                    state_d = S_IDLE;
                else if (bus.i_pause)
                    state_d = S_PAUSE;
                else
                    state_d = S_WAIT_H;
            end
            default: begin
                if (bus.i_stop) begin
                    state_d = S_IDLE;
                end else if (bus.i_pause) begin
                    state_d = S_PAUSE;
                end else begin
                    case (state_q)
                        S_WAIT_L: if (lrc_q && !bus.i_lrc) state_d = S_SKIP;
                        S_SKIP:   state_d = S_SHIFT;
                        S_SHIFT:  if (bit_cnt_q == 4'd15) state_d = S_WRITE;
                        S_WAIT_H: if (bus.i_lrc) state_d = S_WAIT_L;
                        default:  state_d = state_q;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            lrc_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lrc_q   <= bus.i_lrc;
            if (start_new) begin
                addr_q <= '0;
                len_q  <= '0;
                full_q <= 1'b0;
            end
            if (state_q == S_SKIP)
                bit_cnt_q <= '0;
            if (state_q == S_SHIFT) begin
                shift_q   <= shift_nxt;
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            // o_data only moves when a complete word is about to be written
            if (state_q == S_SHIFT && state_d == S_WRITE)
                data_q <= shift_nxt;
            if (state_q == S_WRITE) begin
                len_q <= len_q + ADDR_W'(1);
                if (addr_q == ADDR_MAX)
                    full_q <= 1'b1;
                else
                    addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

`ifdef AUD_REC_PEAK_EN
    logic [15:0] peak_q;
    logic [15:0] abs_w;

    // two's-complement magnitude; -32768 has no positive twin, so clamp it
    always_comb begin
        abs_w = data_q;
        if (data_q == 16'h8000)
            abs_w = 16'h7FFF;
        else if (data_q[15])
            abs_w = ~data_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            peak_q <= '0;
        else if (start_new)
            peak_q <= '0;
        else if (state_q == S_WRITE && abs_w > peak_q)
            peak_q <= abs_w;
    end

    assign bus.o_peak = peak_q;
`else
    assign bus.o_peak = '0;
`endif

    assign bus.o_address = addr_q;
    assign bus.o_data    = data_q;
    assign bus.o_wen     = wen;
    assign bus.o_len     = len_q;
    assign bus.o_state   = state_out;
    assign bus.o_full    = full_q;
endmodule
